// File: rtl/sd_pkg.sv
// Shared SD definitions: frame layout constants, transmitter state encoding
// and the serial CRC7 step used by both the command transmitter and the
// response receiver.
package sd_pkg;

   localparam int unsigned SD_FRAME_BITS = 48;
   localparam logic [6:0]  SD_CRC7_POLY  = 7'h09;   // x^7 + x^3 + 1

   localparam logic SD_START_BIT = 1'b0;
   localparam logic SD_TX_BIT    = 1'b1;
   localparam logic SD_END_BIT   = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FINISH
   } sd_tx_state_t;

   // One serial CRC7 step: shift left and fold in the generator when the
   // incoming bit differs from the current MSB.
   function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
      return {crc[5:0], 1'b0} ^ (((din ^ crc[6]) == 1'b1) ? SD_CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_cmd_tx_if.sv
// Host-side request/status bundle of the SD command transmitter.
//   start      : one-cycle request to send
//   cmd_index  : 6-bit command index
//   cmd_arg    : 32-bit command argument
//   abort      : synchronous abort of the frame in flight
//   busy       : frame in progress
//   done       : one-cycle pulse when the end bit completes
// master = host controller, slave = transmitter.
interface sd_cmd_tx_if;

   logic        start;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic        abort;
   logic        busy;
   logic        done;

   modport master (
      output start, cmd_index, cmd_arg, abort,
      input  busy, done
   );

   modport slave (
      input  start, cmd_index, cmd_arg, abort,
      output busy, done
   );

endinterface

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 accumulator (generator x^7+x^3+1).
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous clear to zero (wins over en)
//   en       : fold din into the running CRC this cycle
//   din      : serial data bit
//   crc      : current remainder
module crc7_serial
   import sd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       en,
   input  logic       din,
   output logic [6:0] crc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc <= '0;
      end else if (clear) begin
         crc <= '0;
      end else if (en) begin
         crc <= crc7_next(crc, din);
      end
   end

endmodule

// File: rtl/sd_cmd_tx.sv
// SD command-line transmitter. Builds the 48-bit command frame
// {start, tx, index, arg, crc7, end} and shifts it out MSB-first, one bit
// per shift_enable strobe from the SD timer.
//   clk, rst     : clock, asynchronous active-high reset
//   host         : request/status bundle (start, cmd_index, cmd_arg,
//                  abort, busy, done)
//   shift_enable : bit strobe from the SD timer
//   timer_enable : keeps the SD timer counting while a frame is in flight
//   clear_byte   : clears the timer byte counter when a frame is accepted
//   cmd_out      : serial CMD line data (registered)
//   cmd_oe       : CMD line output enable
module sd_cmd_tx
   import sd_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   sd_cmd_tx_if.slave     host,
   input  logic           shift_enable,
   output logic           timer_enable,
   output logic           clear_byte,
   output logic           cmd_out,
   output logic           cmd_oe
);

   localparam int unsigned FRAME_BITS = SD_FRAME_BITS;
   localparam logic [6:0]  CRC_POLY   = SD_CRC7_POLY;
   localparam logic [5:0]  CNT_TOP    = 6'(FRAME_BITS - 1);

   sd_tx_state_t state_q, state_d;
   logic [5:0]   bit_cnt_q, bit_cnt_d;
   logic [39:0]  frame_q, frame_d;      // frame bits 47..8
   logic         cmd_out_q, cmd_out_d;
   logic [6:0]   crc;
   logic [6:0]   crc_upd;
   logic         crc_clr;
   logic         crc_en;
   logic         cur_bit;

   // Bit presented on the line for a given down-counter position.
   function automatic logic bit_at(input logic [5:0] cnt,
                                   input logic [39:0] frm,
                                   input logic [6:0] c);
      if (cnt >= 6'd8)
         return frm[cnt - 6'd8];
      else if (cnt != 6'd0)
         return c[3'(cnt - 6'd1)];
      else
         return SD_END_BIT;
   endfunction

   crc7_serial u_crc (
      .clk   (clk),
      .rst   (rst),
      .clear (crc_clr),
      .en    (crc_en),
      .din   (cur_bit),
      .crc   (crc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= CNT_TOP;
         frame_q   <= '0;
         cmd_out_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         frame_q   <= frame_d;
         cmd_out_q <= cmd_out_d;
      end
   end

   assign cur_bit = bit_at(bit_cnt_q, frame_q, crc);

   // The registered line bit for the next position needs the CRC value that
   // the accumulator will hold after this strobe, so the same step is
   // evaluated here in parallel with the sub-module's register update.
   assign crc_upd = crc_en ? crc7_next(crc, cur_bit) : crc;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      frame_d    = frame_q;
      cmd_out_d  = cmd_out_q;
      crc_clr    = 1'b0;
      crc_en     = 1'b0;
      clear_byte = 1'b0;

      unique case (state_q)
         IDLE: begin
            cmd_out_d = 1'b1;
            if (host.start) begin
               state_d    = SHIFT;
               frame_d    = {SD_START_BIT, SD_TX_BIT, host.cmd_index, host.cmd_arg};
               bit_cnt_d  = CNT_TOP;
               crc_clr    = 1'b1;
               clear_byte = 1'b1;
               cmd_out_d  = SD_START_BIT;
            end
         end
         SHIFT: begin
            if (host.abort) begin
               state_d   = IDLE;
               bit_cnt_d = CNT_TOP;
               cmd_out_d = 1'b1;
            end else if (shift_enable) begin
               if (bit_cnt_q == 6'd0) begin
                  state_d   = FINISH;
                  bit_cnt_d = CNT_TOP;
                  cmd_out_d = 1'b1;
               end else begin
                  crc_en    = (bit_cnt_q >= 6'd8);
                  bit_cnt_d = bit_cnt_q - 6'd1;
                  cmd_out_d = bit_at(bit_cnt_q - 6'd1, frame_q, crc_upd);
               end
            end
         end
         FINISH: begin
            state_d   = IDLE;
            cmd_out_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign cmd_out      = cmd_out_q;
   assign cmd_oe       = (state_q == SHIFT);
   assign timer_enable = (state_q == SHIFT);
   assign host.busy    = (state_q == SHIFT);
   assign host.done    = (state_q == FINISH);

endmodule

// File: tb/tb_sd_cmd_tx.sv
module tb_sd_cmd_tx;

   logic clk;
   logic rst;
   logic shift_enable;
   logic timer_enable;
   logic clear_byte;
   logic cmd_out;
   logic cmd_oe;

   sd_cmd_tx_if host ();

   sd_cmd_tx dut (
      .clk          (clk),
      .rst          (rst),
      .host         (host.slave),
      .shift_enable (shift_enable),
      .timer_enable (timer_enable),
      .clear_byte   (clear_byte),
      .cmd_out      (cmd_out),
      .cmd_oe       (cmd_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_vec;
   int unsigned n_err;
   int unsigned cb_cnt;
   int unsigned done_cnt;

   always @(negedge clk) begin
      if (clear_byte) cb_cnt++;
      if (host.done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference frame: message {0,1,index,arg}, CRC7 as the remainder of
   // message * x^7 divided by x^7+x^3+1 (polynomial long division).
   function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] msg;
      logic [46:0] r;
      logic [46:0] g;
      msg = {2'b01, idx, arg};
      r   = {msg, 7'b0};
      g   = 47'h89;
      for (int i = 46; i >= 7; i--)
         if (r[i]) r = r ^ (g << (i - 7));
      return {msg, r[6:0], 1'b1};
   endfunction

   // {done, cmd_oe, busy, timer_enable, cmd_out}
   function automatic logic [7:0] outs();
      return 8'({host.done, cmd_oe, host.busy, timer_enable, cmd_out});
   endfunction

   // abort_at: -1 none, 0..47 abort alone after that many strobes,
   //           48 abort together with the final strobe.
   task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg,
                             input logic [47:0] exp, input int gap_max,
                             input int abort_at, input bit poke,
                             input bit start_in_finish);
      int unsigned cb0;
      int unsigned dn0;
      int gap;
      cb0 = cb_cnt;
      dn0 = done_cnt;
      host.start     = 1'b1;
      host.cmd_index = idx;
      host.cmd_arg   = arg;
      #1;
      chk("clear_byte_on_start", 8'(clear_byte), 8'd1);
      tick();
      host.start = 1'b0;
      chk("start_bit", outs(), 8'b01110 | 8'(exp[47]));
      for (int k = 0; k < 48; k++) begin
         if (k == abort_at) begin
            host.abort = 1'b1;
            tick();
            host.abort = 1'b0;
            chk("abort_outs", outs(), 8'b00001);
            tick();
            chk("abort_no_done", 8'(done_cnt - dn0), 8'd0);
            chk("abort_idle", outs(), 8'b00001);
            return;
         end
         gap = int'($urandom_range(gap_max, 1));
         repeat (gap - 1) tick();
         if (poke && k == 20) begin
            host.start     = 1'b1;
            host.cmd_index = ~idx;
            host.cmd_arg   = ~arg;
            #1;
            chk("busy_start_ignored", 8'(clear_byte), 8'd0);
         end
         shift_enable = 1'b1;
         if (abort_at == 48 && k == 47) host.abort = 1'b1;
         tick();
         shift_enable = 1'b0;
         host.start   = 1'b0;
         host.abort   = 1'b0;
         if (k < 47) chk($sformatf("bit%0d", 46 - k), 8'(cmd_out), 8'(exp[46 - k]));
      end
      if (abort_at == 48) begin
         chk("abort_last_outs", outs(), 8'b00001);
         tick();
         chk("abort_last_no_done", 8'(done_cnt - dn0), 8'd0);
         return;
      end
      chk("finish_outs", outs(), 8'b10001);
      if (start_in_finish) begin
         host.start = 1'b1;
         #1;
         chk("finish_start_ignored", 8'(clear_byte), 8'd0);
      end
      tick();
      host.start = 1'b0;
      chk("idle_after_done", outs(), 8'b00001);
      chk("done_pulses", 8'(done_cnt - dn0), 8'd1);
      chk("clear_byte_pulses", 8'(cb_cnt - cb0), 8'd1);
   endtask

   initial begin
      logic [5:0]  idx;
      logic [31:0] arg;
      int          ab;
      n_vec = 0;
      n_err = 0;
      cb_cnt = 0;
      done_cnt = 0;
      rst = 1'b1;
      shift_enable = 1'b0;
      host.start = 1'b0;
      host.cmd_index = '0;
      host.cmd_arg = '0;
      host.abort = 1'b0;
      tick();
      chk("reset_outs", outs(), 8'b00001);
      chk("reset_clear_byte", 8'(clear_byte), 8'd0);
      tick();
      rst = 1'b0;
      tick();

      // idle: strobes and abort ignored
      shift_enable = 1'b1;
      host.abort = 1'b1;
      repeat (3) begin
         tick();
         chk("idle_strobe", outs(), 8'b00001);
      end
      shift_enable = 1'b0;
      host.abort = 1'b0;

      // known command frames
      send_frame(6'd0,  32'h0000_0000, 48'h4000_0000_0095, 6, -1, 1'b0, 1'b0);
      send_frame(6'd8,  32'h0000_01AA, 48'h4800_0001_AA87, 6, -1, 1'b1, 1'b0);
      send_frame(6'd17, 32'h0000_0000, 48'h5100_0000_0055, 1, -1, 1'b0, 1'b1);

      // abort after 20th strobe, then a full frame
      send_frame(6'd8, 32'h0000_01AA, 48'h4800_0001_AA87, 3, 20, 1'b0, 1'b0);
      send_frame(6'd0, 32'h0000_0000, 48'h4000_0000_0095, 2, -1, 1'b0, 1'b0);
      // abort together with the final strobe
      send_frame(6'd17, 32'h0000_0000, 48'h5100_0000_0055, 2, 48, 1'b0, 1'b0);

      // asynchronous reset mid-frame
      host.start = 1'b1;
      host.cmd_index = 6'd55;
      host.cmd_arg = 32'hDEAD_BEEF;
      tick();
      host.start = 1'b0;
      repeat (5) begin
         shift_enable = 1'b1;
         tick();
         shift_enable = 1'b0;
      end
      #2 rst = 1'b1;
      #1;
      chk("async_rst_outs", outs(), 8'b00001);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_idle", outs(), 8'b00001);
      chk("post_rst_no_done", 8'(host.done), 8'd0);

      // randomized frames, some aborted, checked against the reference
      for (int n = 0; n < 10; n++) begin
         idx = 6'($urandom);
         arg = $urandom;
         ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(48, 0)) : -1;
         send_frame(idx, arg, ref_frame(idx, arg), int'($urandom_range(6, 1)),
                    ab, 1'($urandom), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sd_cmd_tx.md
Name: sd_cmd_tx

Overview:
SD command-line transmitter that sits directly downstream of the SD clock/bit timer. It accepts a 6-bit command index and a 32-bit argument, then builds the 48-bit SD command frame: start bit, transmission bit, index, argument, CRC7 and end bit. It shifts the frame out MSB-first, advancing one bit per shift_enable strobe from the timer. It drives the timer's enable and byte-clear and reports completion to the host-side controller.

Parameters:
FRAME_BITS, 48, command frame length in bits (fixed by the SD spec; not for override)
CRC_POLY, 7'h09, CRC7 generator x^7+x^3+1

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
start  in  1  one-cycle request to send; sampled only in IDLE
cmd_index  in  6  command index; latched on accepted start
cmd_arg  in  32  command argument; latched on accepted start
abort  in  1  synchronous abort of the frame in flight
shift_enable  in  1  bit strobe from the SD timer (one cycle wide)
timer_enable  out  1  enable to the SD timer counters
clear_byte  out  1  clear to the timer byte counter
cmd_out  out  1  serial CMD line data
cmd_oe  out  1  CMD line output enable
busy  out  1  frame in progress
done  out  1  one-cycle pulse when the end bit completes

Behaviour:
- Reset (async, rst=1), and in IDLE: cmd_out=1, cmd_oe=0, busy=0, done=0, timer_enable=0, clear_byte=0.
  - Internal: state=IDLE, bit_cnt=47, crc=0, frame reg=0.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE -> SHIFT, on start=1:
  - Latch frame[47:8] = {1'b0, 1'b1, cmd_index, cmd_arg}.
  - crc := 0, bit_cnt := 47, clear_byte=1 for that cycle.
- SHIFT outputs: busy=1, cmd_oe=1, timer_enable=1.
  - cmd_out = current bit, registered.
  - Start bit (0) is on cmd_out the cycle after start was accepted, i.e. latency of 1 clk.
- Bit source by bit_cnt:
  - 47..8: frame[bit_cnt].
  - 7..1: crc[bit_cnt-1], CRC MSB first.
  - 0: 1'b1 (end bit).
- CRC update: on each shift_enable while bit_cnt>=8, fb = bit ^ crc[6]; crc := {crc[5:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - CRC is frozen from bit_cnt=7 onward.
- Each shift_enable in SHIFT decrements bit_cnt and presents the next bit on the following clk.
- shift_enable while bit_cnt=0: SHIFT -> FINISH.
- FINISH (one clk): done=1, cmd_out=1, cmd_oe=0, timer_enable=0, busy=0; then -> IDLE.
- Boundary and simultaneous conditions:
  - start while busy: ignored, no latch.
  - start and done in the same cycle: start ignored; host re-issues it.
  - shift_enable in IDLE/FINISH: ignored.
  - abort=1 in SHIFT: next clk -> IDLE with cmd_oe=0, cmd_out=1, no done pulse. abort in IDLE is a no-op.
  - abort and the final shift_enable together: abort wins, no done.
  - rst mid-frame: outputs return to reset values immediately (async); no done.
  - cmd_index/cmd_arg changing during SHIFT: no effect on the frame.
- Width rules:
  - bit_cnt is 6 bits unsigned, never wraps; it stops at 0 and leaves via FINISH.
  - crc is 7 bits.

Decomposition:
- Shared package sd_pkg holds:
  - state enum sd_tx_state_t {IDLE, SHIFT, FINISH}
  - localparams SD_FRAME_BITS=48 and SD_CRC7_POLY=7'h09
  - SD_START_BIT=0, SD_TX_BIT=1, SD_END_BIT=1
- One sub-module, crc7_serial, with ports clk, rst, clear, en, din and crc[6:0].
  - It is reused later by the response receiver.

Test Plan:
- CMD0, arg 0x00000000, shift_enable every 6 clk -> serial stream 0x400000000095 MSB-first; CRC=0x4A; done one clk after the 48th strobe.
- CMD8, arg 0x000001AA -> stream 0x48000001AA87; CMD17, arg 0 -> 0x510000000055.
- Pulse start again while busy, and set shift_enable high in IDLE -> frame unchanged, no second frame, outputs stay at idle values.
- abort asserted after the 20th strobe -> next clk cmd_oe=0, cmd_out=1, busy=0, no done; a following start sends a correct full frame.
- Assert rst asynchronously mid-frame (between clk edges) -> outputs reach reset values before the next clk edge; after release, IDLE behaviour.
- Back-to-back: start the cycle after done -> second frame starts with cmd_out=0 one clk later; clear_byte pulses once per frame.
